// File: rtl/cursor_controller_if.sv
// Button, occupancy and cursor/select signals between the board pins, game FSM and cursor overlay.
// The slave modport is the cursor controller; the master modport is whoever drives the buttons.
interface cursor_controller_if;
  logic       enable;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_select;
  logic [8:0] cell_occupied;
  logic [3:0] sel_position;
  logic       select_valid;
  logic       select_reject;
  logic [3:0] select_index;

  modport slave (
    input  enable, btn_up, btn_down, btn_left, btn_right, btn_select, cell_occupied,
    output sel_position, select_valid, select_reject, select_index
  );

  modport master (
    output enable, btn_up, btn_down, btn_left, btn_right, btn_select, cell_occupied,
    input  sel_position, select_valid, select_reject, select_index
  );
endinterface

// File: rtl/cursor_controller.sv
// Purpose: debounced 5-button 3x3 cursor with select pulses; define CURSOR_WRAP_EN for modulo-3 wrap at grid edges.
// Latency: raw press held steady -> cursor/pulse update DEBOUNCE_CYCLES+4 edges later.
// Backpressure: none; events arriving with enable=0 or losing arbitration are dropped.
module cursor_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RESET_POS       = 4
) (
  input logic                 clk,
  input logic                 rst,
  cursor_controller_if.slave  bus
);

  localparam int NB = 5;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // Button bit order: 0 select, 1 up, 2 down, 3 left, 4 right
  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] r_stable;
  logic [NB-1:0] r_stable_d;
  logic [NB-1:0] r_press;
  logic [CW-1:0] r_cnt [NB];

  logic [1:0] r_row;
  logic [1:0] r_col;
  logic [3:0] r_pos;
  logic       r_sel_vld;
  logic       r_sel_rej;
  logic [3:0] r_sel_idx;

  logic [1:0] w_row_n;
  logic [1:0] w_col_n;
  logic       w_sel_vld;
  logic       w_sel_rej;

  assign w_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_select};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_press    <= '0;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= ~r_stable[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Single action per cycle: select > up > down > left > right
  always_comb begin
    w_row_n   = r_row;
    w_col_n   = r_col;
    w_sel_vld = 1'b0;
    w_sel_rej = 1'b0;
    if (bus.enable) begin
      if (r_press[0]) begin
        if (bus.cell_occupied[r_pos]) w_sel_rej = 1'b1;
        else                          w_sel_vld = 1'b1;
      end else if (r_press[1]) begin
        if (r_row != 2'd0) w_row_n = r_row - 2'd1;
        else if (WRAP)     w_row_n = 2'd2;
      end else if (r_press[2]) begin
        if (r_row != 2'd2) w_row_n = r_row + 2'd1;
        else if (WRAP)     w_row_n = 2'd0;
      end else if (r_press[3]) begin
        if (r_col != 2'd0) w_col_n = r_col - 2'd1;
        else if (WRAP)     w_col_n = 2'd2;
      end else if (r_press[4]) begin
        if (r_col != 2'd2) w_col_n = r_col + 2'd1;
        else if (WRAP)     w_col_n = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row     <= 2'(RESET_POS / 3);
      r_col     <= 2'(RESET_POS % 3);
      r_pos     <= 4'(RESET_POS);
      r_sel_vld <= 1'b0;
      r_sel_rej <= 1'b0;
      r_sel_idx <= 4'd0;
    end else begin
      r_row     <= w_row_n;
      r_col     <= w_col_n;
      r_pos     <= ({2'b00, w_row_n} * 4'd3) + {2'b00, w_col_n};
      r_sel_vld <= w_sel_vld;
      r_sel_rej <= w_sel_rej;
      if (w_sel_vld) r_sel_idx <= r_pos;
    end
  end

  assign bus.sel_position  = r_pos;
  assign bus.select_valid  = r_sel_vld;
  assign bus.select_reject = r_sel_rej;
  assign bus.select_index  = r_sel_idx;

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench for cursor_controller with DEBOUNCE_CYCLES=4, RESET_POS=4; expectations follow CURSOR_WRAP_EN.
module tb_cursor_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  cursor_controller_if u_if ();

  cursor_controller #(
    .DEBOUNCE_CYCLES(4),
    .RESET_POS      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] B_SEL = 5'b00001;
  localparam logic [4:0] B_UP  = 5'b00010;
  localparam logic [4:0] B_DN  = 5'b00100;
  localparam logic [4:0] B_LF  = 5'b01000;
  localparam logic [4:0] B_RT  = 5'b10000;

`ifdef CURSOR_WRAP_EN
  localparam int EXP_RIGHT_FROM5 = 3;
  localparam int EXP_UP_TWICE    = 7;
`else
  localparam int EXP_RIGHT_FROM5 = 5;
  localparam int EXP_UP_TWICE    = 1;
`endif

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_btns(input logic [4:0] m);
    u_if.btn_select = m[0];
    u_if.btn_up     = m[1];
    u_if.btn_down   = m[2];
    u_if.btn_left   = m[3];
    u_if.btn_right  = m[4];
  endtask

  // Hold buttons long enough to fire, release until quiet again, counting select pulses throughout
  task automatic press(input logic [4:0] m, output int nv, output int nr);
    nv = 0;
    nr = 0;
    drive_btns(m);
    repeat (12) begin
      tick();
      nv += int'(u_if.select_valid);
      nr += int'(u_if.select_reject);
    end
    drive_btns(5'b0);
    repeat (12) begin
      tick();
      nv += int'(u_if.select_valid);
      nr += int'(u_if.select_reject);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int nv, nr;

  initial begin
    u_if.enable        = 1'b1;
    u_if.cell_occupied = 9'b0;
    drive_btns(5'b0);
    rst = 1'b1;
    repeat (2) tick();
    check("reset_pos", int'(u_if.sel_position), 4);
    check("reset_valid", int'(u_if.select_valid), 0);
    check("reset_reject", int'(u_if.select_reject), 0);
    check("reset_index", int'(u_if.select_index), 0);
    rst = 1'b0;

    // 3-cycle glitches never survive debounce
    nv = 0;
    for (int k = 0; k < 4; k++) begin
      drive_btns(B_RT);
      repeat (3) tick();
      drive_btns(5'b0);
      repeat (5) begin
        tick();
        nv += int'(u_if.select_valid);
      end
    end
    check("glitch_pos", int'(u_if.sel_position), 4);
    check("glitch_pulses", nv, 0);

    // Exact latency: move lands on the 8th edge after the rise
    drive_btns(B_RT);
    repeat (7) tick();
    check("lat_before", int'(u_if.sel_position), 4);
    tick();
    check("lat_at8", int'(u_if.sel_position), 5);
    repeat (15) tick();
    check("hold_no_repeat", int'(u_if.sel_position), 5);
    drive_btns(5'b0);
    repeat (12) tick();
    check("release_no_move", int'(u_if.sel_position), 5);

    press(B_RT, nv, nr);
    check("right_edge", int'(u_if.sel_position), EXP_RIGHT_FROM5);

    do_reset();
    press(B_UP, nv, nr);
    check("up_once", int'(u_if.sel_position), 1);
    press(B_UP, nv, nr);
    check("up_twice", int'(u_if.sel_position), EXP_UP_TWICE);

    do_reset();
    press(B_DN, nv, nr);
    check("down_once", int'(u_if.sel_position), 7);
    press(B_LF, nv, nr);
    check("left_once", int'(u_if.sel_position), 6);
    press(B_UP, nv, nr);
    check("up_from6", int'(u_if.sel_position), 3);

    do_reset();
    u_if.cell_occupied = 9'b0;
    press(B_SEL, nv, nr);
    check("sel_empty_valid", nv, 1);
    check("sel_empty_reject", nr, 0);
    check("sel_empty_index", int'(u_if.select_index), 4);
    check("sel_keeps_pos", int'(u_if.sel_position), 4);

    u_if.cell_occupied = 9'b000010000;
    press(B_SEL, nv, nr);
    check("sel_occ_valid", nv, 0);
    check("sel_occ_reject", nr, 1);
    check("sel_occ_index", int'(u_if.select_index), 4);

    u_if.cell_occupied = 9'b0;
    press(B_SEL | B_UP, nv, nr);
    check("prio_sel_valid", nv, 1);
    check("prio_sel_reject", nr, 0);
    check("prio_sel_pos", int'(u_if.sel_position), 4);

    press(B_UP | B_DN, nv, nr);
    check("prio_up_over_down", int'(u_if.sel_position), 1);

    // Reset while left is mid-debounce, button still held
    do_reset();
    drive_btns(B_LF);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_pos", int'(u_if.sel_position), 4);
    repeat (7) tick();
    check("mid_rst_before", int'(u_if.sel_position), 4);
    tick();
    check("mid_rst_at8", int'(u_if.sel_position), 3);
    repeat (12) tick();
    check("mid_rst_single", int'(u_if.sel_position), 3);
    drive_btns(5'b0);
    repeat (12) tick();

    u_if.enable = 1'b0;
    press(B_RT, nv, nr);
    check("dis_move", int'(u_if.sel_position), 3);
    press(B_SEL, nv, nr);
    check("dis_valid", nv, 0);
    check("dis_reject", nr, 0);

    // Held through enable rising must not fire
    drive_btns(B_RT);
    repeat (12) tick();
    u_if.enable = 1'b1;
    repeat (12) tick();
    check("held_enable_rise", int'(u_if.sel_position), 3);
    drive_btns(5'b0);
    repeat (12) tick();
    press(B_RT, nv, nr);
    check("after_enable", int'(u_if.sel_position), 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
